// File: rtl/octo_motion.sv
// Octopus enemy motion/life-cycle controller: frame-ticked horizontal patrol with
// edge bounce, triangle-wave bob, and a hit -> flash -> hidden -> respawn sequence.
module octo_motion #(
  parameter int X_MIN          = 100,
  parameter int X_MAX          = 639,
  parameter int X_START        = 320,
  parameter int Y_BASE         = 240,
  parameter int SPEED          = 2,
  parameter int BOB_AMP        = 8,
  parameter int HIT_FRAMES     = 32,
  parameter int RESPAWN_FRAMES = 60,
  parameter int V_TRIG         = 481
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] hcount,
  input  logic [10:0] vcount,
  input  logic        run,
  input  logic        hit,
  output logic [11:0] octoX,
  output logic [11:0] octoY,
  output logic        octo_visible,
  output logic [7:0]  hits
);

  typedef enum logic [1:0] {
    SWIM    = 2'd0,
    HIT     = 2'd1,
    RESPAWN = 2'd2
  } state_t;

  localparam logic signed [12:0] XMIN13   = 13'(X_MIN);
  localparam logic signed [12:0] XMAX13   = 13'(X_MAX);
  localparam logic signed [12:0] SPEED13  = 13'(SPEED);
  localparam logic [11:0]        XSTART12 = 12'(X_START);
  localparam logic [11:0]        YBASE12  = 12'(Y_BASE);
  localparam logic signed [5:0]  BOB_HI   = 6'(BOB_AMP);
  localparam logic signed [5:0]  BOB_LO   = 6'(-BOB_AMP);
  localparam logic [7:0]         HIT_T    = 8'(HIT_FRAMES);
  localparam logic [7:0]         RESP_T   = 8'(RESPAWN_FRAMES);

  state_t            state_q;
  logic [11:0]       x_q;
  logic [11:0]       y_q;
  logic              dir_left_q;
  logic              bob_down_q;
  logic signed [5:0] bob_q;
  logic [7:0]        timer_q;
  logic              vis_q;
  logic [7:0]        hits_q;
  logic              cond_q;

  logic              cond_d;
  logic              tick_d;
  logic signed [12:0] x_ext_d;
  logic signed [12:0] nx_d;
  logic signed [5:0] bob_d;
  logic              bob_down_d;
  logic [11:0]       y_d;
  logic [7:0]        timer_dec_d;

  always_comb begin
    cond_d      = (hcount == 11'd0) && (vcount == 11'(V_TRIG));
    tick_d      = cond_d && !cond_q;
    x_ext_d     = {x_q[11], x_q};
    nx_d        = dir_left_q ? (x_ext_d - SPEED13) : (x_ext_d + SPEED13);
    timer_dec_d = timer_q - 8'd1;
    bob_d       = bob_q;
    bob_down_d  = bob_down_q;
    // At either extreme the bob dwells for one frame while it reverses.
    if (!bob_down_q && (bob_q == BOB_HI)) begin
      bob_down_d = 1'b1;
    end else if (bob_down_q && (bob_q == BOB_LO)) begin
      bob_down_d = 1'b0;
    end else if (bob_down_q) begin
      bob_d = bob_q - 6'sd1;
    end else begin
      bob_d = bob_q + 6'sd1;
    end
    y_d = YBASE12 + {{6{bob_d[5]}}, bob_d};
  end

  always_ff @(posedge clk) begin
    // Edge detector keeps tracking even while paused so resuming never fakes a tick.
    cond_q <= rst ? 1'b0 : cond_d;
    if (rst) begin
      state_q    <= SWIM;
      x_q        <= XSTART12;
      y_q        <= YBASE12;
      dir_left_q <= 1'b0;
      bob_down_q <= 1'b0;
      bob_q      <= '0;
      timer_q    <= '0;
      vis_q      <= 1'b1;
      hits_q     <= '0;
    end else if (run) begin
      case (state_q)
        SWIM: begin
          vis_q <= 1'b1;
          if (hit) begin
            state_q <= HIT;
            timer_q <= HIT_T;
            vis_q   <= HIT_T[2];
            if (hits_q != 8'hFF) hits_q <= hits_q + 8'd1;
          end else if (tick_d) begin
            if (!dir_left_q && (nx_d >= XMAX13)) begin
              x_q        <= XMAX13[11:0];
              dir_left_q <= 1'b1;
            end else if (dir_left_q && (nx_d <= XMIN13)) begin
              x_q        <= XMIN13[11:0];
              dir_left_q <= 1'b0;
            end else begin
              x_q <= nx_d[11:0];
            end
            bob_q      <= bob_d;
            bob_down_q <= bob_down_d;
            y_q        <= y_d;
          end
        end
        HIT: begin
          if (tick_d) begin
            if (timer_q == 8'd1) begin
              state_q <= RESPAWN;
              timer_q <= RESP_T;
              vis_q   <= 1'b0;
            end else begin
              timer_q <= timer_dec_d;
              vis_q   <= timer_dec_d[2];
            end
          end
        end
        RESPAWN: begin
          vis_q <= 1'b0;
          if (tick_d) begin
            if (timer_q == 8'd1) begin
              state_q    <= SWIM;
              x_q        <= XSTART12;
              y_q        <= YBASE12;
              bob_q      <= '0;
              bob_down_q <= 1'b0;
              dir_left_q <= 1'b0;
              vis_q      <= 1'b1;
            end else begin
              timer_q <= timer_dec_d;
            end
          end
        end
        default: begin
          state_q    <= SWIM;
          x_q        <= XSTART12;
          y_q        <= YBASE12;
          dir_left_q <= 1'b0;
          bob_down_q <= 1'b0;
          bob_q      <= '0;
          timer_q    <= '0;
          vis_q      <= 1'b1;
        end
      endcase
    end
  end

  assign octoX        = x_q;
  assign octoY        = y_q;
  assign octo_visible = vis_q;
  assign hits         = hits_q;

endmodule

// File: tb/tb_octo_motion.sv
// Directed bench for octo_motion: patrol/bounce, bob, hit/flash/respawn timing,
// tick de-duplication, pause, hit saturation and mid-respawn reset.
module tb_octo_motion;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        run;
  logic        hit;
  logic [11:0] octoX;
  logic [11:0] octoY;
  logic        octo_visible;
  logic [7:0]  hits;

  int checks_cnt   = 0;
  int failures_cnt = 0;

  always #5 clk = ~clk;

  octo_motion dut (
    .clk          (clk),
    .rst          (rst),
    .hcount       (hcount),
    .vcount       (vcount),
    .run          (run),
    .hit          (hit),
    .octoX        (octoX),
    .octoY        (octoY),
    .octo_visible (octo_visible),
    .hits         (hits)
  );

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      failures_cnt++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s = %0d", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_tick();
    hcount = 11'd0;
    vcount = 11'd481;
    step();
    hcount = 11'd1;
    vcount = 11'd0;
    step();
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic pulse_hit();
    hit = 1'b1;
    step();
    hit = 1'b0;
  endtask

  initial begin
    rst = 1'b1; run = 1'b1; hit = 1'b0; hcount = 11'd1; vcount = 11'd0;
    @(negedge clk);
    step();
    step();
    rst = 1'b0;
    check_value("rst_x", 32'(octoX), 32'd320);
    check_value("rst_y", 32'(octoY), 32'd240);
    check_value("rst_vis", 32'(octo_visible), 32'd1);
    check_value("rst_hits", 32'(hits), 32'd0);

    // Patrol and bob
    tick_n(1);
    check_value("t1_x", 32'(octoX), 32'd322);
    check_value("t1_y", 32'(octoY), 32'd241);
    tick_n(7);
    check_value("t8_y", 32'(octoY), 32'd248);
    tick_n(1);
    check_value("t9_y", 32'(octoY), 32'd248);
    tick_n(1);
    check_value("t10_x", 32'(octoX), 32'd340);
    check_value("t10_y", 32'(octoY), 32'd247);

    // Right edge bounce
    tick_n(149);
    check_value("pre_edge_x", 32'(octoX), 32'd638);
    tick_n(1);
    check_value("edge_r_x", 32'(octoX), 32'd639);
    tick_n(1);
    check_value("after_r_x", 32'(octoX), 32'd637);

    // Left edge bounce
    tick_n(268);
    check_value("pre_left_x", 32'(octoX), 32'd101);
    tick_n(1);
    check_value("edge_l_x", 32'(octoX), 32'd100);
    tick_n(1);
    check_value("after_l_x", 32'(octoX), 32'd102);

    // hcount held at 0 for two clocks gives a single tick
    hcount = 11'd0; vcount = 11'd481;
    step();
    step();
    hcount = 11'd1; vcount = 11'd0;
    step();
    check_value("dedup_x", 32'(octoX), 32'd104);

    // Paused: ticks and hits are ignored
    run = 1'b0;
    tick_n(3);
    pulse_hit();
    run = 1'b1;
    check_value("pause_x", 32'(octoX), 32'd104);
    check_value("pause_hits", 32'(hits), 32'd0);
    check_value("pause_vis", 32'(octo_visible), 32'd1);

    // Hit -> flash -> hidden -> respawn
    pulse_hit();
    check_value("hit_hits", 32'(hits), 32'd1);
    check_value("hit_vis0", 32'(octo_visible), 32'd0);
    tick_n(1);
    check_value("hit_t1_vis", 32'(octo_visible), 32'd1);
    check_value("hit_t1_x", 32'(octoX), 32'd104);
    tick_n(3);
    check_value("hit_t4_vis", 32'(octo_visible), 32'd1);
    tick_n(1);
    check_value("hit_t5_vis", 32'(octo_visible), 32'd0);
    pulse_hit();
    check_value("hit_in_hit", 32'(hits), 32'd1);
    tick_n(3);
    check_value("hit_t8_vis", 32'(octo_visible), 32'd0);
    tick_n(1);
    check_value("hit_t9_vis", 32'(octo_visible), 32'd1);
    tick_n(19);
    check_value("hit_t28_vis", 32'(octo_visible), 32'd1);
    tick_n(1);
    check_value("hit_t29_vis", 32'(octo_visible), 32'd0);
    tick_n(3);
    check_value("resp_enter_vis", 32'(octo_visible), 32'd0);
    pulse_hit();
    check_value("hit_in_resp", 32'(hits), 32'd1);
    tick_n(59);
    check_value("resp_t91_vis", 32'(octo_visible), 32'd0);
    check_value("resp_t91_x", 32'(octoX), 32'd104);
    tick_n(1);
    check_value("respawn_vis", 32'(octo_visible), 32'd1);
    check_value("respawn_x", 32'(octoX), 32'd320);
    check_value("respawn_y", 32'(octoY), 32'd240);

    // Hit wins over a simultaneous tick
    tick_n(3);
    check_value("pre_hit_x", 32'(octoX), 32'd326);
    check_value("pre_hit_y", 32'(octoY), 32'd243);
    hcount = 11'd0; vcount = 11'd481; hit = 1'b1;
    step();
    hit = 1'b0; hcount = 11'd1; vcount = 11'd0;
    step();
    check_value("hit_tick_x", 32'(octoX), 32'd326);
    check_value("hit_tick_y", 32'(octoY), 32'd243);
    check_value("hit_tick_vis", 32'(octo_visible), 32'd0);
    check_value("hit_tick_hits", 32'(hits), 32'd2);

    // Reset mid-respawn
    tick_n(37);
    check_value("mid_resp_vis", 32'(octo_visible), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_value("rst2_x", 32'(octoX), 32'd320);
    check_value("rst2_y", 32'(octoY), 32'd240);
    check_value("rst2_vis", 32'(octo_visible), 32'd1);
    check_value("rst2_hits", 32'(hits), 32'd0);

    // Hit counter saturation
    for (int i = 0; i < 255; i++) begin
      pulse_hit();
      tick_n(92);
    end
    check_value("sat255_hits", 32'(hits), 32'd255);
    check_value("sat255_vis", 32'(octo_visible), 32'd1);
    pulse_hit();
    check_value("sat256_hits", 32'(hits), 32'd255);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
    $finish;
  end

endmodule
